// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART 8N1 receiver with 1-entry valid/ready holding register
// Framing errors and overruns are reported as single-cycle pulses.
module uart_rx_ctrl #(
   parameter int CLKS_PER_BIT = 3454,
   parameter int CNT_W        = 16
) (
   input  logic       memory_clk,
   input  logic       I_rst_n,
   input  logic       I_rx,
   output logic [7:0] O_data,
   output logic       O_valid,
   input  logic       I_ready,
   output logic       O_frame_err,
   output logic       O_overrun,
   output logic       O_busy
);

   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HI} state_t;

   state_t           state_q;
   logic             sync1_q, rx_s_q;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic [2:0]       idx_q;
   logic [7:0]       shreg_q, data_q;
   logic             done_q, valid_q, frame_err_q, overrun_q, busy_q;
   logic             tick_start, tick_bit;

   always_comb begin
      timer_d    = timer_q + CNT_W'(1);
      tick_start = (timer_q == HALF_M1);
      tick_bit   = (timer_q == BIT_M1);
   end

   always_ff @(posedge memory_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         state_q     <= S_IDLE;
         sync1_q     <= 1'b1;
         rx_s_q      <= 1'b1;
         timer_q     <= '0;
         idx_q       <= '0;
         shreg_q     <= '0;
         data_q      <= '0;
         done_q      <= 1'b0;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         sync1_q     <= I_rx;
         rx_s_q      <= sync1_q;
         done_q      <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;

         case (state_q)
            S_IDLE: begin
               if (!rx_s_q) begin
                  state_q <= S_START;
                  timer_q <= '0;
                  busy_q  <= 1'b1;
               end
            end
            S_START: begin
               if (tick_start) begin
                  timer_q <= '0;
                  idx_q   <= '0;
                  if (!rx_s_q) begin
                     state_q <= S_DATA;
                  end else begin
                     state_q <= S_IDLE;
                     busy_q  <= 1'b0;
                  end
               end else begin
                  timer_q <= timer_d;
               end
            end
            S_DATA: begin
               if (tick_bit) begin
                  timer_q <= '0;
                  shreg_q <= {rx_s_q, shreg_q[7:1]};
                  idx_q   <= idx_q + 3'd1;
                  if (idx_q == 3'd7) state_q <= S_STOP;
               end else begin
                  timer_q <= timer_d;
               end
            end
            S_STOP: begin
               if (tick_bit) begin
                  timer_q <= '0;
                  if (rx_s_q) begin
                     state_q <= S_IDLE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     state_q     <= S_WAIT_HI;
                     frame_err_q <= 1'b1;
                  end
               end else begin
                  timer_q <= timer_d;
               end
            end
            S_WAIT_HI: begin
               // A held-low (break) line must not be mistaken for a new start bit.
               if (rx_s_q) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase

         // A byte may load into a register that is being drained in the same cycle.
         if (done_q) begin
            if (!valid_q || I_ready) begin
               data_q  <= shreg_q;
               valid_q <= 1'b1;
            end else begin
               overrun_q <= 1'b1;
            end
         end else if (valid_q && I_ready) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign O_data      = data_q;
   assign O_valid     = valid_q;
   assign O_frame_err = frame_err_q;
   assign O_overrun   = overrun_q;
   assign O_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - directed self-checking bench for uart_rx_ctrl
// Inputs change on the falling edge; outputs are sampled 1 ns after it.
module tb_uart_rx_ctrl;

   localparam int CPB = 16;

   logic       memory_clk;
   logic       I_rst_n;
   logic       I_rx;
   logic [7:0] O_data;
   logic       O_valid;
   logic       I_ready;
   logic       O_frame_err;
   logic       O_overrun;
   logic       O_busy;

   uart_rx_ctrl #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
      .memory_clk (memory_clk),
      .I_rst_n    (I_rst_n),
      .I_rx       (I_rx),
      .O_data     (O_data),
      .O_valid    (O_valid),
      .I_ready    (I_ready),
      .O_frame_err(O_frame_err),
      .O_overrun  (O_overrun),
      .O_busy     (O_busy)
   );

   initial memory_clk = 1'b0;
   always #5 memory_clk = ~memory_clk;

   int n_cmp = 0;
   int n_mis = 0;
   int cyc = 0;
   int fe_cnt = 0;
   int ov_cnt = 0;
   int fe_cyc = 0;
   int rise_cyc = 0;
   int valid_hi = 0;
   logic valid_prev = 1'b0;
   logic [7:0] beats[$];

   always @(posedge memory_clk) cyc <= cyc + 1;

   always @(negedge memory_clk) begin
      #1;
      if (O_valid && !valid_prev) rise_cyc = cyc;
      valid_prev = O_valid;
      if (O_valid) valid_hi++;
      if (O_valid && I_ready) beats.push_back(O_data);
      if (O_frame_err) begin
         fe_cnt++;
         fe_cyc = cyc;
      end
      if (O_overrun) ov_cnt++;
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge memory_clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Start bit, 8 data bits LSB first, stop bit; line left at the stop level.
   task automatic send_byte(input logic [7:0] b, input logic stop);
      I_rx = 1'b0;
      wait_cyc(CPB);
      for (int i = 0; i < 8; i++) begin
         I_rx = b[i];
         wait_cyc(CPB);
      end
      I_rx = stop;
      wait_cyc(CPB);
   endtask

   int t_start;
   int fe0, ov0;

   initial begin
      I_rst_n = 1'b0;
      I_rx    = 1'b1;
      I_ready = 1'b0;
      wait_cyc(3);
      #1;
      check("rst_valid", O_valid, 0);
      check("rst_data", O_data, 0);
      check("rst_ferr", O_frame_err, 0);
      check("rst_ovr", O_overrun, 0);
      check("rst_busy", O_busy, 0);
      @(negedge memory_clk);
      I_rst_n = 1'b1;
      wait_cyc(4);

      // 1: 0xA5 with exact output latency
      I_ready = 1'b1;
      beats.delete();
      valid_hi = 0;
      fe0 = fe_cnt; ov0 = ov_cnt;
      t_start = cyc;
      send_byte(8'hA5, 1'b1);
      wait_cyc(10);
      check("t1_latency", rise_cyc - t_start, 156);
      check("t1_valid_cycles", valid_hi, 1);
      check("t1_beats", beats.size(), 1);
      if (beats.size() > 0) check("t1_data", beats[0], 8'hA5);
      check("t1_ferr", fe_cnt - fe0, 0);
      check("t1_ovr", ov_cnt - ov0, 0);

      // 2: 4-cycle glitch
      beats.delete();
      fe0 = fe_cnt; ov0 = ov_cnt;
      I_rx = 1'b0;
      wait_cyc(4);
      I_rx = 1'b1;
      wait_cyc(6);
      check("t2_busy_start", O_busy, 1);
      wait_cyc(1);
      check("t2_busy_idle", O_busy, 0);
      wait_cyc(20);
      check("t2_beats", beats.size(), 0);
      check("t2_valid", O_valid, 0);
      check("t2_ferr", fe_cnt - fe0, 0);
      check("t2_ovr", ov_cnt - ov0, 0);

      // 3: bad stop bit followed by a held-low line
      beats.delete();
      fe0 = fe_cnt; ov0 = ov_cnt;
      t_start = cyc;
      send_byte(8'h3C, 1'b0);
      wait_cyc(39);
      check("t3_busy_low", O_busy, 1);
      check("t3_valid", O_valid, 0);
      wait_cyc(1);
      I_rx = 1'b1;
      wait_cyc(5);
      check("t3_busy_released", O_busy, 0);
      check("t3_ferr_count", fe_cnt - fe0, 1);
      check("t3_ferr_time", ((fe_cyc - t_start) >= 155) && ((fe_cyc - t_start) <= 156), 1);
      check("t3_beats", beats.size(), 0);
      check("t3_ovr", ov_cnt - ov0, 0);

      // 4: overrun with a stalled consumer
      I_ready = 1'b0;
      beats.delete();
      fe0 = fe_cnt; ov0 = ov_cnt;
      send_byte(8'h11, 1'b1);
      wait_cyc(4);
      check("t4_valid_first", O_valid, 1);
      check("t4_data_first", O_data, 8'h11);
      send_byte(8'h22, 1'b1);
      wait_cyc(4);
      check("t4_ovr", ov_cnt - ov0, 1);
      check("t4_valid_held", O_valid, 1);
      check("t4_data_held", O_data, 8'h11);
      I_ready = 1'b1;
      wait_cyc(1);
      check("t4_valid_drop", O_valid, 0);
      check("t4_beats", beats.size(), 1);
      if (beats.size() > 0) check("t4_beat_data", beats[0], 8'h11);
      check("t4_ferr", fe_cnt - fe0, 0);

      // 5: back-to-back frames
      beats.delete();
      fe0 = fe_cnt; ov0 = ov_cnt;
      send_byte(8'h00, 1'b1);
      send_byte(8'hFF, 1'b1);
      send_byte(8'h80, 1'b1);
      wait_cyc(10);
      check("t5_beats", beats.size(), 3);
      if (beats.size() == 3) begin
         check("t5_beat0", beats[0], 8'h00);
         check("t5_beat1", beats[1], 8'hFF);
         check("t5_beat2", beats[2], 8'h80);
      end
      check("t5_ferr", fe_cnt - fe0, 0);
      check("t5_ovr", ov_cnt - ov0, 0);

      // 6: reset in data bit 3 while a byte is held
      I_ready = 1'b0;
      send_byte(8'h77, 1'b1);
      wait_cyc(4);
      check("t6_pre_valid", O_valid, 1);
      I_rx = 1'b0;
      wait_cyc(CPB);
      I_rx = 1'b1;
      wait_cyc(3 * CPB + CPB / 2);
      I_rst_n = 1'b0;
      wait_cyc(1);
      check("t6_rst_valid", O_valid, 0);
      check("t6_rst_data", O_data, 0);
      check("t6_rst_ferr", O_frame_err, 0);
      check("t6_rst_ovr", O_overrun, 0);
      check("t6_rst_busy", O_busy, 0);
      wait_cyc(3);
      I_rst_n = 1'b1;
      wait_cyc(4);
      check("t6_idle_after", O_busy, 0);
      beats.delete();
      fe0 = fe_cnt; ov0 = ov_cnt;
      I_ready = 1'b1;
      send_byte(8'h5A, 1'b1);
      wait_cyc(10);
      check("t6_beats", beats.size(), 1);
      if (beats.size() > 0) check("t6_data", beats[0], 8'h5A);
      check("t6_ferr", fe_cnt - fe0, 0);
      check("t6_ovr", ov_cnt - ov0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
